keypad_scan4x4: RTL and testbench

- Scanner for a 4x4 matrix keypad. Sits directly upstream of the 4-digit lock FSM and drives that block's key[3:0] / valid_key inputs.
- Drives one column low at a time and samples the four row lines. Debounces press and release.
- Emits exactly one single-cycle valid_key pulse per physical key press, with a stable 4-bit key code.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/keypad_scan4x4_sync2.sv | 27 ++
 rtl/keypad_scan4x4.sv | 170 +++++++++++++++++
 tb/tb_keypad_scan4x4.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key codes and helpers for the 4x4 keypad scanner.
// Key codes are {row_idx, col_idx}; rows and columns are active-low on the pins.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  localparam logic [3:0] KEY_LOCK  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  localparam logic [3:0] KEY_CHGPW = 4'hE;

  function automatic logic [2:0] onehot_cnt4(input logic [3:0] v);
    onehot_cnt4 = {2'b00, ~v[0]} + {2'b00, ~v[1]} + {2'b00, ~v[2]} + {2'b00, ~v[3]};
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scan4x4_sync2.sv
// Generic-width two-flop synchroniser; resets to all-ones so idle pulled-up rows read as released.
// Latency two clk cycles, no backpressure.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 keypad scanner: one-hot-low column drive, debounced press/release, one valid_key strobe per press
// (no backpressure; downstream must take each strobe). Define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_scan4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int REPEAT_DLY   = 50000,
  parameter int REPEAT_PER   = 10000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       valid_key,
  output logic       pressed
);

  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYC - 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CYC < 1 || REPEAT_DLY < 2 || REPEAT_PER < 2) begin : g_cfg_bad
    $error("keypad_scan4x4: illegal parameter set");
  end

  logic [3:0] row_s;

  sync2 #(.W(4)) u_row_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (row_n),
    .q_o  (row_s)
  );

  logic [2:0] low_cnt_d;
  logic [1:0] low_row_d;

  always_comb begin
    low_cnt_d = onehot_cnt4(row_s);
    low_row_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_row_d = 2'(i);
    end
  end

  scan_state_t   state_q;
  logic [1:0]    col_idx_q;
  logic [1:0]    row_idx_q;
  logic [3:0]    col_n_q;
  logic [3:0]    pat_q;
  logic [DW-1:0] dwell_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    key_q;
  logic          valid_q;
  logic          pressed_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

  // hold_q counts cycles since the last strobe; rep_q selects the first-repeat or periodic target.
  logic [RW-1:0] hold_q;
  logic          rep_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      col_n_q   <= 4'b1110;
      pat_q     <= 4'hF;
      dwell_q   <= '0;
      cnt_q     <= '0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      hold_q    <= '0;
      rep_q     <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            if (low_cnt_d == 3'd1) begin
              state_q   <= DEBOUNCE;
              pat_q     <= row_s;
              row_idx_q <= low_row_d;
              cnt_q     <= '0;
            end else begin
              col_idx_q <= col_idx_q + 2'd1;
              col_n_q   <= col_drive(col_idx_q + 2'd1);
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (row_s != pat_q) begin
            state_q <= SCAN;
            dwell_q <= '0;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q   <= EMIT;
            valid_q   <= 1'b1;
            key_q     <= {row_idx_q, col_idx_q};
            pressed_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        EMIT: begin
          state_q <= RELEASE;
          cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
          hold_q  <= RW'(1);
          rep_q   <= 1'b0;
`endif
        end

        RELEASE: begin
          if (row_s == 4'hF) begin
            if (cnt_q == DEB_LAST) begin
              state_q   <= SCAN;
              pressed_q <= 1'b0;
              cnt_q     <= '0;
              dwell_q   <= '0;
              col_idx_q <= col_idx_q + 2'd1;
              col_n_q   <= col_drive(col_idx_q + 2'd1);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (row_s == pat_q) begin
            if (hold_q == (rep_q ? PER_LAST : DLY_LAST)) begin
              valid_q <= 1'b1;
              hold_q  <= '0;
              rep_q   <= 1'b1;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
`endif
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign col_n     = col_n_q;
  assign key       = key_q;
  assign valid_key = valid_q;
  assign pressed   = pressed_q;

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Self-checking bench for keypad_scan4x4 with a behavioural keypad matrix and a key-code scoreboard.
// Honours KEYPAD_REPEAT_EN to select single-strobe or auto-repeat expectations.
module tb_keypad_scan4x4;
  import keypad_pkg::*;

  logic       clk;
  logic       rstn;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key;
  logic       valid_key;
  logic       pressed;

  logic [15:0] keymask;

  keypad_scan4x4 #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8),
    .REPEAT_DLY   (40),
    .REPEAT_PER   (12)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .row_n     (row_n),
    .col_n     (col_n),
    .key       (key),
    .valid_key (valid_key),
    .pressed   (pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a closed switch at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keymask[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int strobe_cnt = 0;
  int strobe_times[$];
  logic [3:0] exp_q[$];
  logic prev_valid = 1'b0;
  logic locked = 1'b0;
  logic [15:0] dbuf = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Scoreboard / monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid_key) begin
        check("strobe_gap", {31'b0, prev_valid}, 32'd0);
        strobe_times.push_back(cyc);
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_strobe: got key %0h, required no strobe", key);
        end else begin
          e = exp_q.pop_front();
          check("strobe_key", {28'b0, key}, {28'b0, e});
        end
        if (key == KEY_LOCK) begin
          locked = 1'b1;
          dbuf   = 16'h0;
        end else if (key == KEY_ENTER) begin
          if (dbuf == 16'h1234) locked = 1'b0;
          dbuf = 16'h0;
        end else begin
          dbuf = {dbuf[11:0], key};
        end
      end
      prev_valid = valid_key;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (strobe_cnt < n && i < budget) begin
      tick(1);
      i++;
    end
    check(name, strobe_cnt, n);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic press_once(input int r, input int c, input logic [3:0] exp_key);
    exp_q.push_back(exp_key);
    keymask = 16'h0;
    keymask[r*4+c] = 1'b1;
    tick(40);
    keymask = 16'h0;
    tick(15);
    wait_drain(40, "press_drain");
    tick(5);
  endtask

  typedef struct {
    int         r;
    int         c;
    logic [3:0] exp_key;
  } press_vec_t;

  press_vec_t  vecs[5];
  logic [3:0]  col_exp[5];

  initial begin
    int s0;
    int n0;
    int t0;
    int settle;
    logic seen3;

    vecs[0] = '{2, 3, 4'hB};
    vecs[1] = '{0, 0, 4'h0};
    vecs[2] = '{3, 3, 4'hF};
    vecs[3] = '{1, 2, 4'h6};
    vecs[4] = '{3, 0, 4'hC};
    col_exp[0] = 4'b1110;
    col_exp[1] = 4'b1101;
    col_exp[2] = 4'b1011;
    col_exp[3] = 4'b0111;
    col_exp[4] = 4'b1110;

    rstn    = 1'b0;
    keymask = 16'h0;
    tick(3);
    check("rst_col_n", {28'b0, col_n}, 32'hE);
    check("rst_key", {28'b0, key}, 32'h0);
    check("rst_valid", {31'b0, valid_key}, 32'h0);
    check("rst_pressed", {31'b0, pressed}, 32'h0);
    rstn = 1'b1;

    // Column rotation: each column dwells four cycles.
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check("col_rotate", {28'b0, col_n}, {28'b0, col_exp[i]});
      tick(4);
    end

    // Table of clean single presses, with release-debounce timing on pressed.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp_key);
      keymask = 16'h0;
      keymask[vecs[i].r*4+vecs[i].c] = 1'b1;
      tick(40);
      check("pressed_while_held", {31'b0, pressed}, 32'd1);
      keymask = 16'h0;
      tick(8);
      check("pressed_release_hold", {31'b0, pressed}, 32'd1);
      tick(3);
      check("pressed_released", {31'b0, pressed}, 32'd0);
      wait_drain(40, "table_drain");
      tick(10);
    end

    // Bouncing contact: 3-cycle toggles never reach 8 stable cycles.
    s0 = strobe_cnt;
    exp_q.push_back(4'hB);
    for (int i = 0; i < 10; i++) begin
      keymask = (i % 2 == 0) ? 16'h0800 : 16'h0000;
      tick(3);
    end
    check("bounce_no_strobe", strobe_cnt - s0, 0);
    keymask = 16'h0800;
    settle  = cyc;
    wait_strobes(s0 + 1, 60, "bounce_strobe");
    check("bounce_after_stable", (strobe_times[$] - settle >= 8) ? 1 : 0, 1);
    tick(10);
    keymask = 16'h0;
    tick(15);
    wait_drain(10, "bounce_drain");

    // Ghost: two rows low on column 1 must be ignored while scanning continues.
    s0 = strobe_cnt;
    seen3 = 1'b0;
    keymask = 16'h0022;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (col_n == 4'b0111) seen3 = 1'b1;
    end
    keymask = 16'h0;
    check("ghost_no_strobe", strobe_cnt - s0, 0);
    check("ghost_scan_moves", {31'b0, seen3}, 32'd1);
    tick(10);

    // Lock sequence through a downstream lock model.
    locked = 1'b0;
    dbuf   = 16'h0;
    press_once(2, 3, KEY_LOCK);
    check("lock_after_B", {31'b0, locked}, 32'd1);
    press_once(0, 1, 4'h1);
    press_once(0, 2, 4'h2);
    press_once(0, 3, 4'h3);
    press_once(1, 0, 4'h4);
    check("lock_digits", {16'b0, dbuf}, 32'h1234);
    check("lock_still_locked", {31'b0, locked}, 32'd1);
    press_once(3, 0, KEY_ENTER);
    check("unlock_after_C", {31'b0, locked}, 32'd0);

    // Long hold of key 5.
    s0 = strobe_cnt;
    n0 = strobe_times.size();
`ifdef KEYPAD_REPEAT_EN
    repeat (4) exp_q.push_back(4'h5);
    keymask = 16'h0020;
    wait_strobes(s0 + 1, 60, "repeat_first");
    t0 = (strobe_times.size() > n0) ? strobe_times[n0] : cyc;
    for (int i = 0; i < 200 && cyc < t0 + 70; i++) tick(1);
    keymask = 16'h0;
    tick(15);
    wait_drain(5, "repeat_drain");
    check("repeat_count", strobe_cnt - s0, 4);
    if (strobe_times.size() >= n0 + 4) begin
      check("repeat_dly", strobe_times[n0+1] - t0, 40);
      check("repeat_per1", strobe_times[n0+2] - t0, 52);
      check("repeat_per2", strobe_times[n0+3] - t0, 64);
    end else begin
      n_checks++;
      $display("FAIL repeat_times: got %0d strobes, required 4", strobe_times.size() - n0);
    end
`else
    exp_q.push_back(4'h5);
    keymask = 16'h0020;
    tick(100);
    keymask = 16'h0;
    tick(15);
    wait_drain(5, "hold_drain");
    check("hold_single_strobe", strobe_cnt - s0, 1);
    t0 = 0;
`endif
    tick(10);

    // Reset pulsed while a key is held: reset values, then one fresh strobe.
    s0 = strobe_cnt;
    exp_q.push_back(4'h5);
    keymask = 16'h0020;
    wait_strobes(s0 + 1, 60, "midrst_first");
    tick(5);
    check("midrst_pressed_before", {31'b0, pressed}, 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_col_n", {28'b0, col_n}, 32'hE);
    check("midrst_key", {28'b0, key}, 32'h0);
    check("midrst_valid", {31'b0, valid_key}, 32'h0);
    check("midrst_pressed", {31'b0, pressed}, 32'h0);
    tick(3);
    rstn = 1'b1;
    exp_q.push_back(4'h5);
    wait_strobes(s0 + 2, 80, "midrst_fresh");
    tick(3);
    keymask = 16'h0;
    tick(15);
    wait_drain(5, "midrst_drain");
    check("midrst_count", strobe_cnt - s0, 2);
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
